// File: rtl/mini68k_prefetch_if.sv
// Instruction-memory fetch bus between the mini68k prefetch queue (master) and
// instruction memory (slave).
interface mini68k_prefetch_if #(
  parameter int ADDR_W = 24
);
  // mem_req rises together with mem_addr, and both stay stable until a cycle
  // with mem_ack=1. That cycle completes the transfer and carries mem_rdata.
  // mem_ack seen while mem_req=0 means nothing.
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [15:0]       mem_rdata;

  modport master (output mem_req, output mem_addr, input mem_ack, input mem_rdata);
  modport slave  (input mem_req, input mem_addr, output mem_ack, output mem_rdata);
endinterface

// File: rtl/mini68k_prefetch.sv
// Instruction prefetch queue for the mini68k: fetches opcode words ahead of the
// control unit, buffers them in a small FIFO and flushes on a PC reload.
module mini68k_prefetch #(
  parameter int                DEPTH    = 4,
  parameter int                ADDR_W   = 24,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pc_load,
  input  logic [ADDR_W-1:0]   pc_load_addr,
  mini68k_prefetch_if.master  bus,
  output logic [15:0]         ir,
  output logic [ADDR_W-1:0]   ir_pc,
  output logic                ir_valid,
  input  logic                ir_consume,
  output logic [1:0]          dbg_state
);
  localparam int                PTR_W    = $clog2(DEPTH);
  localparam logic [PTR_W:0]    FULL     = (PTR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] START_PC = RESET_PC & ~ADDR_W'(1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [15:0]       word_q [DEPTH];
  logic [ADDR_W-1:0] pc_q   [DEPTH];
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [PTR_W:0]    count, count_nxt;
  logic [ADDR_W-1:0] fetch_pc, fetch_pc_nxt, addr_nxt;
  logic              req_nxt, ack, push, pop;

  always_comb begin
    ack  = bus.mem_req & bus.mem_ack;
    push = ack && (state == REQ) && !pc_load;
    pop  = ir_consume && ir_valid && !pc_load;

    count_nxt = count;
    if (pc_load)          count_nxt = '0;
    else if (push && !pop) count_nxt = count + 1'b1;
    else if (!push && pop) count_nxt = count - 1'b1;

    fetch_pc_nxt = fetch_pc;
    if (pc_load)   fetch_pc_nxt = pc_load_addr & ~ADDR_W'(1);
    else if (push) fetch_pc_nxt = fetch_pc + ADDR_W'(2);

    // A reload clears the queue, so count_nxt=0 sends IDLE/REQ straight to the new PC.
    state_nxt = state;
    addr_nxt  = bus.mem_addr;
    case (state)
      IDLE: begin
        if (count_nxt < FULL) begin
          state_nxt = REQ;
          addr_nxt  = fetch_pc_nxt;
        end
      end
      REQ: begin
        if (pc_load && !ack) begin
          state_nxt = DISCARD;
        end else if (ack) begin
          if (count_nxt < FULL) begin
            state_nxt = REQ;
            addr_nxt  = fetch_pc_nxt;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      DISCARD: begin
        if (ack) begin
          state_nxt = REQ;
          addr_nxt  = fetch_pc_nxt;
        end
      end
      default: state_nxt = IDLE;
    endcase
    req_nxt = (state_nxt != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      bus.mem_req  <= 1'b0;
      bus.mem_addr <= START_PC;
      fetch_pc     <= START_PC;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
    end else begin
      state        <= state_nxt;
      bus.mem_req  <= req_nxt;
      bus.mem_addr <= addr_nxt;
      fetch_pc     <= fetch_pc_nxt;
      count        <= count_nxt;
      if (pc_load) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // Entry storage needs no reset: count guards every read.
  always_ff @(posedge clk) begin
    if (push) begin
      word_q[wr_ptr] <= bus.mem_rdata;
      pc_q[wr_ptr]   <= bus.mem_addr;
    end
  end

  assign ir_valid  = (count != '0);
  assign ir        = ir_valid ? word_q[rd_ptr] : 16'h0000;
  assign ir_pc     = ir_valid ? pc_q[rd_ptr] : '0;
  assign dbg_state = state;
endmodule

// File: tb/tb_mini68k_prefetch.sv
// Bench for mini68k_prefetch: directed scenarios plus random traffic, all
// checked every cycle against a queue-level model of the prefetcher.
module tb_mini68k_prefetch;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = 24;

  logic              clk = 1'b0;
  logic              rst, pc_load, ir_consume, ir_valid;
  logic [ADDR_W-1:0] pc_load_addr, ir_pc;
  logic [15:0]       ir;
  logic [1:0]        dbg_state;

  mini68k_prefetch_if #(.ADDR_W(ADDR_W)) bus ();

  mini68k_prefetch #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .RESET_PC(24'h000000)) dut (
    .clk          (clk),
    .rst          (rst),
    .pc_load      (pc_load),
    .pc_load_addr (pc_load_addr),
    .bus          (bus),
    .ir           (ir),
    .ir_pc        (ir_pc),
    .ir_valid     (ir_valid),
    .ir_consume   (ir_consume),
    .dbg_state    (dbg_state)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model: queue of {pc, word}; m_req = "queue has room"; stale = a request
  // issued before a reload is still waiting for its (discarded) ack.
  logic [39:0]       exp_q[$];
  logic [ADDR_W-1:0] m_pc, stale_addr;
  logic              m_req, stale;

  int lat, wait_cnt, lat_lo, lat_hi;

  function automatic logic [15:0] word_of(input logic [23:0] a);
    return a[15:0] ^ {a[23:16], a[23:16]};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic compare_model();
    chk("mem_req", 32'(bus.mem_req), 32'(m_req));
    if (m_req) chk("mem_addr", 32'(bus.mem_addr), 32'(stale ? stale_addr : m_pc));
    chk("ir_valid", 32'(ir_valid), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      chk("ir", 32'(ir), 32'(exp_q[0][15:0]));
      chk("ir_pc", 32'(ir_pc), 32'(exp_q[0][39:16]));
    end else begin
      chk("ir_empty", 32'(ir), 32'h0);
      chk("ir_pc_empty", 32'(ir_pc), 32'h0);
    end
  endtask

  task automatic model_step(input logic r, input logic pl, input logic [23:0] pa,
                            input logic ack_in, input logic cons);
    logic ack;
    ack = m_req && ack_in;
    if (r) begin
      exp_q.delete();
      m_pc  = '0;
      m_req = 1'b0;
      stale = 1'b0;
      return;
    end
    if (pl) begin
      if (m_req && !ack) begin
        if (!stale) begin
          stale      = 1'b1;
          stale_addr = m_pc;
        end
      end else if (ack) begin
        stale = 1'b0;
      end
      exp_q.delete();
      m_pc = {pa[23:1], 1'b0};
    end else begin
      if (cons && exp_q.size() > 0) void'(exp_q.pop_front());
      if (ack) begin
        if (stale) begin
          stale = 1'b0;
        end else begin
          exp_q.push_back({m_pc, word_of(m_pc)});
          m_pc = m_pc + 24'd2;
        end
      end
    end
    m_req = exp_q.size() < DEPTH;
  endtask

  // One clock: check outputs, drive inputs and the memory responder, advance model.
  task automatic cycle(input logic r, input logic pl, input logic [23:0] pa, input logic cons);
    logic req_now, ack_v;
    compare_model();
    req_now      = bus.mem_req;
    rst          = r;
    pc_load      = pl;
    pc_load_addr = pa;
    ir_consume   = cons;
    if (req_now) begin
      ack_v         = (wait_cnt >= lat);
      bus.mem_rdata = word_of(bus.mem_addr);
    end else begin
      ack_v         = ($urandom_range(0, 3) == 0);
      bus.mem_rdata = 16'($urandom);
    end
    bus.mem_ack = ack_v;
    model_step(r, pl, pa, ack_v, cons);
    @(posedge clk);
    if (r || (req_now && ack_v)) begin
      wait_cnt = 0;
      lat      = $urandom_range(lat_lo, lat_hi);
    end else if (req_now) begin
      wait_cnt++;
    end
    @(negedge clk);
  endtask

  task automatic set_lat(input int lo, input int hi);
    lat_lo = lo;
    lat_hi = hi;
    lat    = $urandom_range(lo, hi);
  endtask

  initial begin
    rst = 1'b1; pc_load = 1'b0; pc_load_addr = '0; ir_consume = 1'b0;
    bus.mem_ack = 1'b0; bus.mem_rdata = '0;
    exp_q.delete(); m_pc = '0; stale_addr = '0; m_req = 1'b0; stale = 1'b0;
    wait_cnt = 0;
    set_lat(0, 0);
    @(negedge clk);

    // Reset, then zero-wait fill with no consume.
    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 0);
    chk("rst_mem_req", 32'(bus.mem_req), 32'h0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 32'h0);
    chk("rst_ir_valid", 32'(ir_valid), 32'h0);
    chk("rst_ir", 32'(ir), 32'h0);
    chk("rst_ir_pc", 32'(ir_pc), 32'h0);
    cycle(0, 0, 0, 0);
    chk("fill_req", 32'(bus.mem_req), 32'h1);
    chk("fill_addr0", 32'(bus.mem_addr), 32'h0);
    for (int k = 1; k < 4; k++) begin
      cycle(0, 0, 0, 0);
      chk("fill_addr", 32'(bus.mem_addr), 32'(2 * k));
      chk("fill_ir", 32'(ir), 32'h0);
    end
    cycle(0, 0, 0, 0);
    chk("full_req", 32'(bus.mem_req), 32'h0);
    chk("full_valid", 32'(ir_valid), 32'h1);
    chk("full_ir_pc", 32'(ir_pc), 32'h0);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    chk("full_hold_req", 32'(bus.mem_req), 32'h0);
    cycle(0, 0, 0, 1);
    chk("pop_req", 32'(bus.mem_req), 32'h1);
    chk("pop_addr", 32'(bus.mem_addr), 32'h8);
    chk("pop_ir", 32'(ir), 32'h0002);
    chk("pop_ir_pc", 32'(ir_pc), 32'h2);

    // Slow memory, consume every cycle.
    set_lat(3, 3);
    for (int i = 0; i < 60; i++) cycle(0, 0, 0, 1);

    // Reload during an outstanding request (ack two cycles later).
    set_lat(2, 2);
    cycle(1, 0, 0, 0);
    cycle(0, 0, 0, 0);
    cycle(0, 1, 24'h001001, 0);
    chk("disc_req", 32'(bus.mem_req), 32'h1);
    chk("disc_addr", 32'(bus.mem_addr), 32'h0);
    chk("disc_valid", 32'(ir_valid), 32'h0);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    chk("reload_addr", 32'(bus.mem_addr), 32'h001000);
    chk("reload_valid", 32'(ir_valid), 32'h0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0);
    chk("reload_ir_valid", 32'(ir_valid), 32'h1);
    chk("reload_ir_pc", 32'(ir_pc), 32'h001000);

    // Reload coincident with ack and consume at count=2.
    set_lat(0, 0);
    cycle(1, 0, 0, 0);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    chk("co_count2_ir_pc", 32'(ir_pc), 32'h0);
    cycle(0, 1, 24'h000100, 1);
    chk("co_valid", 32'(ir_valid), 32'h0);
    chk("co_req", 32'(bus.mem_req), 32'h1);
    chk("co_addr", 32'(bus.mem_addr), 32'h000100);
    cycle(0, 0, 0, 0);
    chk("co_ir_pc", 32'(ir_pc), 32'h000100);
    chk("co_ir", 32'(ir), 32'h0100);

    // Address wrap at the top of the space.
    cycle(0, 1, 24'hFFFFFF, 0);
    chk("wrap_addr_hi", 32'(bus.mem_addr), 32'hFFFFFE);
    cycle(0, 0, 0, 0);
    chk("wrap_addr", 32'(bus.mem_addr), 32'h000000);
    chk("wrap_ir_pc", 32'(ir_pc), 32'hFFFFFE);
    chk("wrap_ir", 32'(ir), 32'h0001);

    // Reset while a request is outstanding.
    set_lat(3, 3);
    wait_cnt = 0;
    cycle(0, 0, 0, 0);
    chk("pre_rst_req", 32'(bus.mem_req), 32'h1);
    chk("pre_rst_valid", 32'(ir_valid), 32'h1);
    cycle(1, 0, 0, 0);
    chk("mid_rst_req", 32'(bus.mem_req), 32'h0);
    chk("mid_rst_valid", 32'(ir_valid), 32'h0);

    // Random traffic.
    set_lat(0, 3);
    for (int i = 0; i < 3000; i++) begin
      cycle(logic'($urandom_range(0, 199) == 0),
            logic'($urandom_range(0, 29) == 0),
            24'($urandom),
            logic'($urandom_range(0, 1)));
    end
    cycle(0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mini68k_prefetch.md
Name: mini68k_prefetch

Overview:
- Instruction prefetch queue sitting directly upstream of the mini68k control unit.
- Fetches 16-bit opcode words from instruction memory over a req/ack handshake and buffers them in a small FIFO.
- Presents the head word to the control unit as ir/ir_valid and pops it on ir_consume.
- Supports a PC reload (branch/exception) that flushes the queue and restarts fetch at a new address.

Parameters:
- DEPTH, 4, FIFO entries (power of 2, >=2).
- ADDR_W, 24, byte-address width.
- RESET_PC, 0, fetch address after reset (bit 0 forced to 0).

Ports:
- clk  input  1  system clock.
- rst  input  1  reset; one clock; reset is synchronous and active-high.
- pc_load  input  1  pulse: flush queue and restart fetch at pc_load_addr.
- pc_load_addr  input  ADDR_W  new fetch byte address (bit 0 ignored, treated as 0).
- mem_req  output  1  fetch request to instruction memory.
- mem_addr  output  ADDR_W  byte address of the requested word.
- mem_ack  input  1  memory has returned mem_rdata this cycle; ignored unless mem_req=1.
- mem_rdata  input  16  fetched word, valid when mem_ack=1.
- ir  output  16  head-of-queue instruction word; 16'h0000 when ir_valid=0.
- ir_pc  output  ADDR_W  byte address of the ir word.
- ir_valid  output  1  queue non-empty.
- ir_consume  input  1  pop the head word; ignored when ir_valid=0.

Behaviour:
- Reset (rst=1 at posedge): queue empty, fetch_pc=RESET_PC, state=IDLE.
  - Output reset values: mem_req=0, mem_addr=RESET_PC, ir_valid=0, ir=0, ir_pc=0.
  - Reset mid-transaction abandons the outstanding request; any mem_ack after reset with mem_req=0 is ignored.
- At most one request outstanding. mem_req, mem_addr and the state are registered.
- FSM states:
  - IDLE: mem_req=0. Go to REQ when the post-edge count < DEPTH, with mem_addr=fetch_pc. First cycle after reset release: IDLE, then REQ on the following cycle.
  - REQ: mem_req=1, mem_addr held stable until mem_ack. On mem_ack:
    - Push mem_rdata with address mem_addr; fetch_pc += 2 (wraps mod 2^ADDR_W).
    - If the count after this edge's push/pop is < DEPTH, stay in REQ with mem_addr = new fetch_pc (back-to-back requests); otherwise go to IDLE.
    - Zero-wait memory (ack in the first req cycle) is legal.
  - DISCARD: mem_req=1 with the old address held until mem_ack. The returned data is dropped, then go to REQ at fetch_pc.
- Latency: a word acked at edge N has ir_valid=1 in cycle N+1. Empty to first ir_valid with zero-wait memory: 1 cycle after the ack edge.
- Pop: ir_consume && ir_valid removes the head at the edge.
  - Push and pop at the same edge leaves count unchanged. At count=1 the pushed word becomes head.
  - ir_consume while empty: no effect.
  - No push can occur when full, because no request is issued.
- pc_load (highest priority over push, pop and ir_consume):
  - Queue cleared (ir_valid=0 next cycle); fetch_pc = {pc_load_addr[ADDR_W-1:1],0}.
  - In IDLE, or in REQ with mem_ack=1 in the same cycle: acked data is discarded, next state REQ with the new address.
  - In REQ with mem_ack=0: go to DISCARD.
  - pc_load while already in DISCARD: update fetch_pc only, stay in DISCARD.
- ir and ir_pc are read from registered storage via the read pointer (no extra cycle). Pointers wrap mod DEPTH; count is 0..DEPTH.

Test Plan:
- Reset release, zero-wait memory returning word = address value → mem_req rises 1 cycle after reset release, mem_addr 0,2,4,6 back-to-back. With no consume, mem_req drops once 4 entries are held. ir=0x0000, ir_pc=0.
- Full queue (DEPTH=4), pulse ir_consume once → count 3, mem_req reasserts next cycle at addr 8; ir becomes the word from addr 2.
- Memory with 3-cycle ack latency, consume every cycle → mem_addr stable for all wait cycles; ir_valid toggles; no word lost or duplicated, verified against an address-ordered scoreboard.
- pc_load=1, addr=0x001001, during an outstanding request (ack 2 cycles later) → DISCARD; stale data dropped; next request at 0x001000; first ir_pc=0x001000.
- pc_load coincident with mem_ack and ir_consume at count=2 → queue empty next cycle, acked word dropped, REQ at the new address.
- fetch_pc=0xFFFFFE → after ack, next mem_addr=0x000000; ir_pc of that word=0xFFFFFE. Also: assert rst while in REQ → mem_req=0 and ir_valid=0 next cycle.
